peak_detector: RTL and testbench

PEAK_DETECTOR -- requirements
Module: peak_detector

---
 rtl/peak_detector.sv | 121 ++++++++++++
 tb/tb_peak_detector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/peak_detector.sv
// ============================================================================
// Module      : peak_detector
// Description : Windowed maximum search over enabled magnitude samples,
//               reporting peak value, in-window index and threshold flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module peak_detector #(
    parameter int DATA_WIDTH    = 19,
    parameter int WINDOW_LENGTH = 1024,
    parameter int INDEX_WIDTH   = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  dataIn,
    input  logic [DATA_WIDTH-1:0]  threshold,
    output logic [DATA_WIDTH-1:0]  peakValue,
    output logic [INDEX_WIDTH-1:0] peakIndex,
    output logic                   peakFound,
    output logic                   peakValid
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(WINDOW_LENGTH - 1);
    localparam logic [INDEX_WIDTH-1:0] ONE_IDX  = INDEX_WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t                 state_q,     state_d;
    logic [INDEX_WIDTH-1:0] cnt_q,       cnt_d;
    logic [DATA_WIDTH-1:0]  max_q,       max_d;
    logic [INDEX_WIDTH-1:0] idx_q,       idx_d;
    logic [DATA_WIDTH-1:0]  pk_val_q,    pk_val_d;
    logic [INDEX_WIDTH-1:0] pk_idx_q,    pk_idx_d;
    logic                   pk_found_q,  pk_found_d;
    logic                   pk_valid_q,  pk_valid_d;

    // Strict greater-than keeps the earliest index on ties.
    logic                   greater;
    logic [DATA_WIDTH-1:0]  cand_val;
    logic [INDEX_WIDTH-1:0] cand_idx;

    assign greater  = (dataIn > max_q);
    assign cand_val = greater ? dataIn : max_q;
    assign cand_idx = greater ? cnt_q  : idx_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            max_q      <= '0;
            idx_q      <= '0;
            pk_val_q   <= '0;
            pk_idx_q   <= '0;
            pk_found_q <= 1'b0;
            pk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            idx_q      <= idx_d;
            pk_val_q   <= pk_val_d;
            pk_idx_q   <= pk_idx_d;
            pk_found_q <= pk_found_d;
            pk_valid_q <= pk_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        max_d      = max_q;
        idx_d      = idx_q;
        pk_val_d   = pk_val_q;
        pk_idx_d   = pk_idx_q;
        pk_found_d = pk_found_q;
        pk_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    max_d   = dataIn;
                    idx_d   = '0;
                    cnt_d   = ONE_IDX;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (enable) begin
                    max_d = cand_val;
                    idx_d = cand_idx;
                    if (cnt_q == LAST_IDX) begin
                        // Publish the result including the final sample; the next
                        // cycle is IDLE so a back-to-back sample becomes index 0.
                        pk_val_d   = cand_val;
                        pk_idx_d   = cand_idx;
                        pk_found_d = (cand_val >= threshold);
                        pk_valid_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + ONE_IDX;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign peakValue = pk_val_q;
    assign peakIndex = pk_idx_q;
    assign peakFound = pk_found_q;
    assign peakValid = pk_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_peak_detector.sv
// ============================================================================
// Module      : tb_peak_detector
// Description : Directed-vector scoreboard bench for peak_detector (8-sample window).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_peak_detector;

    localparam int DW = 19;
    localparam int IW = 3;
    localparam int WL = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] threshold;
    logic [DW-1:0] peakValue;
    logic [IW-1:0] peakIndex;
    logic          peakFound;
    logic          peakValid;

    peak_detector #(
        .DATA_WIDTH    (DW),
        .WINDOW_LENGTH (WL),
        .INDEX_WIDTH   (IW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .dataIn    (dataIn),
        .threshold (threshold),
        .peakValue (peakValue),
        .peakIndex (peakIndex),
        .peakFound (peakFound),
        .peakValid (peakValid)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] v;
        logic [IW-1:0] i;
        logic          f;
        int            cyc;
    } exp_t;

    typedef logic [DW-1:0] win_t [WL];

    exp_t q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every peakValid pulse must match the oldest expected result, on its cycle.
    always @(negedge clock) begin
        if (peakValid === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_valid: got peakValid=1 at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("valid_cycle", cyc,       e.cyc);
                chk("peakValue",   peakValue, 32'(e.v));
                chk("peakIndex",   peakIndex, 32'(e.i));
                chk("peakFound",   peakFound, 32'(e.f));
            end
        end
    end

    task automatic put(input logic [DW-1:0] d);
        enable = 1'b1;
        dataIn = d;
        @(posedge clock);
        #1;
        enable = 1'b0;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Call directly after the window-final put: result is due at the following negedge.
    task automatic expect_pk(input logic [DW-1:0] v, input logic [IW-1:0] i, input logic f);
        exp_t e;
        e.v   = v;
        e.i   = i;
        e.f   = f;
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic send_win(input win_t w);
        for (int k = 0; k < WL; k++) put(w[k]);
    endtask

    win_t w_a;
    win_t w_b;
    win_t w_c;
    win_t w_d;

    initial begin
        w_a = '{19'd5, 19'd9, 19'd3, 19'd15697, 19'd2, 19'd15697, 19'd1, 19'd0};
        w_b = '{19'd81, 19'd81, 19'd81, 19'd81, 19'd81, 19'd81, 19'd81, 19'd81};
        w_c = '{19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd0, 19'd524287};
        w_d = '{19'd10, 19'd20, 19'd30, 19'd40, 19'd50, 19'd60, 19'd70, 19'd80};

        reset     = 1'b1;
        enable    = 1'b0;
        dataIn    = '0;
        threshold = '0;
        #12;
        chk("rst_peakValue", peakValue, 0);
        chk("rst_peakIndex", peakIndex, 0);
        chk("rst_peakFound", peakFound, 0);
        chk("rst_peakValid", peakValid, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);

        // Mixed samples with a tie at the max: earliest index wins.
        threshold = 19'd1000;
        send_win(w_a);
        expect_pk(19'd15697, 3'd0 + 3'd3, 1'b1);
        idle(2);

        // Constant window below threshold.
        threshold = 19'd100;
        send_win(w_b);
        expect_pk(19'd81, 3'd0, 1'b0);
        idle(2);

        // Same as first window with a 3-cycle enable gap after sample 2.
        threshold = 19'd1000;
        for (int k = 0; k < 3; k++) put(w_a[k]);
        idle(3);
        for (int k = 3; k < WL; k++) put(w_a[k]);
        expect_pk(19'd15697, 3'd3, 1'b1);
        idle(2);

        // Back-to-back windows, including full-scale sample at the last index.
        send_win(w_a);
        expect_pk(19'd15697, 3'd3, 1'b1);
        send_win(w_c);
        expect_pk(19'd524287, 3'd7, 1'b1);
        idle(2);

        // Threshold equal to the peak counts as found.
        threshold = 19'd15697;
        send_win(w_a);
        expect_pk(19'd15697, 3'd3, 1'b1);
        idle(2);

        // Threshold only matters on the final edge: low during the window, peak+1 at the end.
        threshold = 19'd0;
        for (int k = 0; k < WL - 1; k++) put(w_a[k]);
        threshold = 19'd15698;
        put(w_a[WL-1]);
        expect_pk(19'd15697, 3'd3, 1'b0);

        // Outputs hold between window ends regardless of threshold changes.
        threshold = 19'd0;
        idle(4);
        chk("hold_peakValue", peakValue, 15697);
        chk("hold_peakIndex", peakIndex, 3);
        chk("hold_peakFound", peakFound, 0);
        chk("hold_peakValid", peakValid, 0);

        // Reset mid-window: partial window is discarded, outputs clear immediately.
        threshold = 19'd50;
        for (int k = 0; k < 5; k++) put(19'd1000 + 19'(k));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_peakValue", peakValue, 0);
        chk("midrst_peakIndex", peakIndex, 0);
        chk("midrst_peakFound", peakFound, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_win(w_d);
        expect_pk(19'd80, 3'd7, 1'b1);

        idle(6);
        chk("queue_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
